// File: rtl/mmm_pkg.sv
// Shared definitions for the mmm_* Montgomery multiplier family.
package mmm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ITER  = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ITER  = ST_ITER,
    FINAL = ST_FINAL
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mmm_digit_step.sv
// One radix-2^D Montgomery iteration: s_ns = (s + ai*b + q*n) / 2^D.
module mmm_digit_step #(
  parameter int N = 32,
  parameter int D = 1
) (
  input  logic [N:0]   s_ps,
  input  logic [D-1:0] a_digit,
  input  logic [N-1:0] b,
  input  logic [N-1:0] n,
  input  logic [D-1:0] n_prime,
  output logic [N:0]   s_ns
);

  localparam int W  = N + D + 1;
  localparam int SW = N + 1;

  logic [W-1:0] t;
  logic [W-1:0] u;
  logic [D-1:0] q;

  // q makes the low D bits of t + q*n zero, so the shift below is exact.
  always_comb begin
    t    = W'(s_ps) + W'(a_digit) * W'(b);
    q    = t[D-1:0] * n_prime;
    u    = t + W'(q) * W'(n);
    s_ns = SW'(u >> D);
  end

endmodule

// File: rtl/mmm_radix.sv
// Sequential radix-2^D Montgomery multiplier: y = a*b*2^(-N) mod n, fully reduced.
//   state | meaning
//   IDLE  | ready=1, waiting for start; operands latched on accept
//   ITER  | one D-bit digit of a consumed per cycle, N/D cycles
//   FINAL | conditional subtraction into y, done pulse
module mmm_radix
  import mmm_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rn,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] n,
  input  logic [D-1:0] n_prime,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] y
);

  localparam int STEPS = N / D;
  localparam int CW    = clog2(STEPS) + 1;

  if (N % D != 0) begin : g_bad_digit
    $error("mmm_radix: N must be a multiple of D");
  end

  state_e         state;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [N-1:0]   n_reg;
  logic [D-1:0]   np_reg;
  logic [N:0]     s;
  logic [N:0]     s_ns;
  logic [N:0]     s_red;
  logic [CW-1:0]  cnt;

  mmm_digit_step #(.N(N), .D(D)) u_step (
    .s_ps    (s),
    .a_digit (a_reg[D-1:0]),
    .b       (b_reg),
    .n       (n_reg),
    .n_prime (np_reg),
    .s_ns    (s_ns)
  );

  // s < 2n, so a single subtraction fully reduces it.
  assign s_red = (s >= {1'b0, n_reg}) ? s - {1'b0, n_reg} : s;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      n_reg  <= '0;
      np_reg <= '0;
      s      <= '0;
      cnt    <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
      y      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            n_reg  <= n;
            np_reg <= n_prime;
            s      <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
            state  <= ITER;
          end
        end
        ITER: begin
          s     <= s_ns;
          a_reg <= a_reg >> D;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(STEPS - 1)) state <= FINAL;
        end
        FINAL: begin
          y     <= N'(s_red);
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmm_radix.md
# mmm_radix

Parametrised sequential Montgomery modular multiplier computing y = a·b·2^(-N) mod n, processing a D-bit digit of a per clock cycle (radix 2^D), with the final conditional subtraction done inside the block so y is always fully reduced. It is the successor to the radix-2, one-bit-per-cycle multiplier and is the multiply primitive for the modular exponentiation datapath. Operands, modulus and modulus inverse are latched at start. The caller may therefore change them while the block is busy.

## Interface
- N, 32: operand and modulus width in bits.
- D, 1: digit width in bits, i.e. a bits consumed per iteration. N % D must be 0, otherwise the block fails at elaboration.
- clk  in  1  clock, rising edge.
- rn  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled only while ready=1.
- a  in  N  multiplier. Requires a < n.
- b  in  N  multiplicand. Requires b < n.
- n  in  N  modulus. Must be odd, n < 2^N.
- n_prime  in  D  equals -n^(-1) mod 2^D, precomputed by the caller.
- ready  out  1  idle; able to accept start.
- done  out  1  one-cycle pulse when y is updated.
- y  out  N  result, held until the next completion.

## Operation
- States: IDLE, ITER, FINAL.
- **IDLE**, ready=1.
  - On start=1: latch a, b, n, n_prime.
  - Clear s (N+1 bits) and the digit counter.
  - Go to ITER.
- **ITER**, one iteration per cycle.
  - ai = low D bits of a_reg.
  - t = s + ai·b.
  - q = (t mod 2^D)·n_prime mod 2^D.
  - s <= (t + q·n) >> D.
  - a_reg <= a_reg >> D; counter++.
  - After the N/D-th iteration, go to FINAL.
- **FINAL**: y <= (s >= n) ? s - n : s (low N bits); done <= 1; go to IDLE.
- Width rules:
  - t + q·n needs N+D+1 bits with no truncation.
  - s stays < 2n, so it fits in N+1 bits.
  - The digit counter is clog2(N/D)+1 bits wide.
- start while ready=0 is ignored. No queuing, no abort.
- Out-of-range inputs (even n, a ≥ n, b ≥ n) are unsupported: the result is unspecified, but the FSM still completes in the same cycle count.
- Reset (rn=0), asynchronous and at any time including mid-operation:
  - state=IDLE, ready=1, done=0, y=0.
  - All internal registers are 0.
  - No done pulse is produced for the aborted operation.

## Timing
- Edge E0 samples start with ready=1.
  - ready falls after E0.
  - Iterations run on edges E1..E(N/D).
  - FINAL runs on edge E(N/D+1).
- After E(N/D+1): done=1 for exactly one cycle, ready=1, y valid.
- Latency is N/D+1 cycles from the accepting edge to done. Examples: N=32,D=1 gives 33; N=8,D=4 gives 3.
- Back-to-back: start asserted in the cycle where done=1 (ready=1) is accepted on the next edge. Throughput is one result per N/D+1 cycles.
- y changes only on the FINAL edge or on reset. It never changes during ITER.
- done and ready are registered outputs with no combinational path from inputs.

## Structure
- Shared package mmm_pkg holds:
  - the state encoding localparams (IDLE, ITER, FINAL);
  - a clog2 helper function for counter width.
  - Future mmm_* blocks share these.
- Sub-module mmm_digit_step: purely combinational, params N and D.
  - Inputs: s_ps, a_digit, b, n, n_prime. Output: s_ns.
  - Unit-testable on its own; it is the radix-2^D generalisation of the existing single-iteration block.
- Top level holds the FSM, counter, operand registers, final subtractor and output registers.

## Test plan
- **Identity (N=8, n=239, R mod n=17):** for D=1 (n_prime=1), D=2 (n_prime=1), D=4 (n_prime=1):
  - a=1, b=1 → y=225 (=R^(-1) mod 239);
  - a=17, b=100 → y=100;
  - a=0, b=55 → y=0.
- **Latency:** N=8, D=4, start at E0 → ready=0 for E1..E3, then done=1 and ready=1 after E3, exactly one cycle wide. With D=1, done comes after E9.
- **Busy protection:**
  - start pulsed with new a/b/n mid-ITER is ignored.
  - Changing input pins after E0 does not alter y (a=17, b=100 still gives y=100).
- **Back-to-back:** start held high across two operations → second accepted in the done cycle. Results 225 then 100 with no idle gap.
- **Reset mid-operation:** rn low at E2 → ready=1, done=0, y=0 immediately (asynchronous). After release, a fresh start yields the correct result with no stale done.
- **Random compare:** 10k random odd n, random a,b < n, for N=32 with D in {1,2,4,8}, against a behavioural model. Coverage must hit the pre-subtraction cases s ≥ n and s < n, n=2^N-1, and a=n-1, b=n-1.
